exe_unit_seq: RTL and testbench

EXE_UNIT_SEQ -- requirements
Module: exe_unit_seq

---
 rtl/exe_unit_seq_pkg.sv | 29 ++
 rtl/exe_unit_seq_if.sv | 24 ++
 rtl/exe_unit_seq_mul.sv | 68 ++++++
 rtl/exe_unit_seq.sv | 162 ++++++++++++++++
 tb/tb_exe_unit_seq.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/exe_unit_seq_pkg.sv
// Shared types and constants for the sequential execution unit.
package exe_pkg;

    // Operation codes presented on i_oper.
    typedef enum logic [2:0] {
        OP_SHL  = 3'd0,
        OP_CMP  = 3'd1,
        OP_BSET = 3'd2,
        OP_CONV = 3'd3,
        OP_MUL  = 3'd4,
        OP_RSV5 = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit positions inside o_status.
    localparam int STAT_PARITY = 0;
    localparam int STAT_OVF    = 1;
    localparam int STAT_ONES   = 2;
    localparam int STAT_ERR    = 3;

endpackage

// File: rtl/exe_unit_seq_if.sv
// Start/done bus between the control unit and the iterative multiplier.
// Handshake: start is a one-cycle pulse carrying arg_a/arg_b; done is a
// one-cycle pulse raised in the cycle product/overflow first hold the final
// value, and they stay valid until the next start or reset.
interface exe_unit_seq_if #(
    parameter int ARG_BITS = 8
);
    logic                start;
    logic [ARG_BITS-1:0] arg_a;
    logic [ARG_BITS-1:0] arg_b;
    logic                done;
    logic [ARG_BITS-1:0] product;
    logic                overflow;

    modport master (
        output start, arg_a, arg_b,
        input  done, product, overflow
    );

    modport slave (
        input  start, arg_a, arg_b,
        output done, product, overflow
    );
endinterface

// File: rtl/exe_unit_seq_mul.sv
// Iterative signed shift-add multiplier, one multiplier bit per cycle.
// The start cycle already folds in bit 0, so the final product is ready
// (done pulses) ARG_BITS cycles after the start edge's cycle begins.
module exe_mul_seq #(
    parameter int ARG_BITS = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    exe_unit_seq_if.slave bus
);

    localparam int W = ARG_BITS;

    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [5:0]     cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [2*W-1:0] a_ext;
    logic [W:0]     upper;

    // Sign-extended multiplicand seen at start.
    always_comb begin
        a_ext = {{W{bus.arg_a[W-1]}}, bus.arg_a};
    end

    // Accumulate partial products; the sign bit of B carries negative weight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.start) begin
                acc_q    <= bus.arg_b[0] ? a_ext : '0;
                mcand_q  <= a_ext << 1;
                mplier_q <= bus.arg_b >> 1;
                cnt_q    <= 6'd1;
                busy_q   <= 1'b1;
            end else if (busy_q) begin
                if (mplier_q[0]) begin
                    acc_q <= (cnt_q == 6'(W-1)) ? acc_q - mcand_q : acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 6'd1;
                if (cnt_q == 6'(W-1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Product fits W signed bits only if the top W+1 bits are all equal.
    always_comb begin
        upper        = acc_q[2*W-1:W-1];
        bus.product  = acc_q[W-1:0];
        bus.overflow = !((&upper) || (~|upper));
        bus.done     = done_q;
    end

endmodule

// File: rtl/exe_unit_seq.sv
// Sequential execution unit: single-cycle ops plus an iterative multiply,
// with a valid/ready request side and a valid/ready result side.
// Handshake: a request transfers when i_valid && o_ready at a rising edge;
// a result transfers when o_valid && i_ready at a rising edge. o_ready is
// high only in IDLE and o_valid only in DONE, so the two never overlap.
module exe_unit_seq
    import exe_pkg::*;
#(
    parameter int ARG_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [2:0]          i_oper,
    input  logic [ARG_BITS-1:0] i_argA,
    input  logic [ARG_BITS-1:0] i_argB,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [ARG_BITS-1:0] o_result,
    output logic [3:0]          o_status
);

    state_e              state_q, state_d;
    op_e                 op_q;
    op_e                 sel_op;
    logic                accept;
    logic                capture;
    logic                mul_start;
    logic [ARG_BITS-1:0] calc_res;
    logic [3:0]          calc_status;
    logic                calc_ovf;
    logic                calc_err;
    int                  b_int;

    exe_unit_seq_if #(.ARG_BITS(ARG_BITS)) mul_bus ();

    assign mul_bus.start = mul_start;
    assign mul_bus.arg_a = i_argA;
    assign mul_bus.arg_b = i_argB;

    exe_mul_seq #(.ARG_BITS(ARG_BITS)) u_mul (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (mul_bus.slave)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake outputs and capture/start strobes.
    always_comb begin
        state_d   = state_q;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_ready = 1'b1;
                accept  = i_valid;
                if (i_valid) begin
                    if (op_e'(i_oper) == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_BUSY;
                    end else begin
                        capture = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (mul_bus.done) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Opcode register; only consulted while the multiplier is running.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_q <= OP_SHL;
        end else if (accept) begin
            op_q <= op_e'(i_oper);
        end
    end

    // Shared result and flag stage: live operands at acceptance, multiplier in BUSY.
    always_comb begin
        calc_res    = '0;
        calc_ovf    = 1'b0;
        calc_err    = 1'b0;
        calc_status = '0;
        b_int       = int'($signed(i_argB));
        sel_op      = (state_q == ST_BUSY) ? op_q : op_e'(i_oper);
        case (sel_op)
            OP_SHL: begin
                if (b_int < 0) begin
                    if (b_int > -ARG_BITS) begin
                        calc_res = i_argA << (-b_int);
                    end
                end else begin
                    calc_err = 1'b1;
                end
            end
            OP_CMP: begin
                calc_res = {{(ARG_BITS-1){1'b0}}, ($signed(i_argA) > $signed(i_argB))};
            end
            OP_BSET: begin
                if (b_int > 0 && b_int < ARG_BITS) begin
                    calc_res = i_argA | (ARG_BITS'(1) << b_int);
                end else begin
                    calc_err = 1'b1;
                end
            end
            OP_CONV: begin
                if (i_argA[ARG_BITS-1]) begin
                    calc_res = {1'b1, ~i_argA[ARG_BITS-2:0]} + ARG_BITS'(1);
                end else begin
                    calc_res = i_argA;
                end
            end
            OP_MUL: begin
                calc_res = mul_bus.product;
                calc_ovf = mul_bus.overflow;
            end
            default: calc_err = 1'b1;
        endcase
        calc_status[STAT_PARITY] = ^calc_res;
        calc_status[STAT_OVF]    = calc_ovf;
        calc_status[STAT_ONES]   = &calc_res;
        calc_status[STAT_ERR]    = calc_err;
    end

    // Output registers load once per operation and hold through DONE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_result <= '0;
            o_status <= '0;
        end else if (capture) begin
            o_result <= calc_res;
            o_status <= calc_status;
        end
    end

endmodule

// File: tb/tb_exe_unit_seq.sv
// Directed bench for exe_unit_seq at ARG_BITS=8.
module tb_exe_unit_seq;
    import exe_pkg::*;

    localparam int W = 8;

    logic         i_clk;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [2:0]   i_oper;
    logic [W-1:0] i_argA;
    logic [W-1:0] i_argB;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result;
    logic [3:0]   o_status;

    int n_vec;
    int n_err;
    logic [W+3:0] exp_q[$];

    exe_unit_seq #(.ARG_BITS(W)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_oper   (i_oper),
        .i_argA   (i_argA),
        .i_argB   (i_argB),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_status (o_status)
    );

    // Clock and watchdog.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one request for a single cycle, then scramble the operands.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_oper  = op;
        i_argA  = a;
        i_argB  = b;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_argA  = ~a;
        i_argB  = a ^ b;
        i_oper  = 3'(op + 3'd1);
    endtask

    // Count cycles from acceptance until o_valid, sampled on falling edges.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            lat++;
            @(negedge i_clk);
            if (o_valid) return;
        end
        lat = 999;
    endtask

    task automatic check_result(input string tag);
        logic [W+3:0] exp;
        exp = exp_q.pop_front();
        check({tag, " result"}, 32'(o_result), 32'(exp[W-1:0]));
        check({tag, " status"}, 32'(o_status), 32'(exp[W+3:W]));
    endtask

    task automatic release_result(input string tag);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        @(negedge i_clk);
        check({tag, " ready_after"}, 32'(o_ready), 32'd1);
        check({tag, " valid_after"}, 32'(o_valid), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int exp_lat,
                         input logic [W-1:0] exp_res, input logic [3:0] exp_stat);
        int lat;
        exp_q.push_back({exp_stat, exp_res});
        send(op, a, b);
        wait_valid(lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_result(tag);
        release_result(tag);
    endtask

    initial begin
        int lat;
        int vcount;
        n_vec   = 0;
        n_err   = 0;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_oper  = '0;
        i_argA  = '0;
        i_argB  = '0;
        i_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge i_clk);
        check("rst ready", 32'(o_ready), 32'd1);
        check("rst valid", 32'(o_valid), 32'd0);
        check("rst result", 32'(o_result), 32'd0);
        check("rst status", 32'(o_status), 32'd0);
        i_rst = 1'b0;

        // Single-cycle operations.
        do_op("shl_a3_bm2",   3'd0, 8'h03, 8'hFE, 1, 8'h0C, 4'b0000);
        do_op("shl_bpos",     3'd0, 8'h03, 8'h03, 1, 8'h00, 4'b1000);
        do_op("shl_a81_bm1",  3'd0, 8'h81, 8'hFF, 1, 8'h02, 4'b0001);
        do_op("shl_bm8",      3'd0, 8'hFF, 8'hF8, 1, 8'h00, 4'b0000);
        do_op("cmp_gt",       3'd1, 8'h05, 8'hFD, 1, 8'h01, 4'b0001);
        do_op("cmp_lt",       3'd1, 8'hFD, 8'h05, 1, 8'h00, 4'b0000);
        do_op("cmp_eq",       3'd1, 8'h05, 8'h05, 1, 8'h00, 4'b0000);
        do_op("bset_b7",      3'd2, 8'h7F, 8'h07, 1, 8'hFF, 4'b0100);
        do_op("bset_b8",      3'd2, 8'h7F, 8'h08, 1, 8'h00, 4'b1000);
        do_op("bset_b0",      3'd2, 8'h10, 8'h00, 1, 8'h00, 4'b1000);
        do_op("conv_neg",     3'd3, 8'hFB, 8'h00, 1, 8'h85, 4'b0001);
        do_op("conv_pos",     3'd3, 8'h35, 8'h00, 1, 8'h35, 4'b0000);
        do_op("op6",          3'd6, 8'h12, 8'h34, 1, 8'h00, 4'b1000);

        // Multiply: latency ARG_BITS+1.
        do_op("mul_m3x5",     3'd4, 8'hFD, 8'h05, 9, 8'hF1, 4'b0001);
        do_op("mul_100x2",    3'd4, 8'h64, 8'h02, 9, 8'hC8, 4'b0011);
        do_op("mul_m128xm1",  3'd4, 8'h80, 8'hFF, 9, 8'h80, 4'b0011);
        do_op("mul_m1xm1",    3'd4, 8'hFF, 8'hFF, 9, 8'h01, 4'b0001);

        // Backpressure: three DONE cycles with i_ready low and a stray request.
        exp_q.push_back({4'b0001, 8'h85});
        send(3'd3, 8'hFB, 8'h00);
        wait_valid(lat);
        check("bp latency", 32'(lat), 32'd1);
        check_result("bp hold0");
        i_valid = 1'b1;
        i_oper  = 3'd1;
        i_argA  = 8'h05;
        i_argB  = 8'h01;
        for (int c = 1; c < 3; c++) begin
            @(negedge i_clk);
            check("bp valid", 32'(o_valid), 32'd1);
            check("bp ready", 32'(o_ready), 32'd0);
            check("bp result", 32'(o_result), 32'h85);
            check("bp status", 32'(o_status), 32'b0001);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        @(negedge i_clk);
        check("bp idle ready", 32'(o_ready), 32'd1);
        check("bp idle valid", 32'(o_valid), 32'd0);
        check("bp idle result", 32'(o_result), 32'h85);
        @(negedge i_clk);
        check("bp stray ignored", 32'(o_valid), 32'd0);

        // Reset four cycles into a multiply.
        send(3'd4, 8'h07, 8'h09);
        repeat (4) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("rmul result", 32'(o_result), 32'd0);
        check("rmul status", 32'(o_status), 32'd0);
        check("rmul valid", 32'(o_valid), 32'd0);
        check("rmul ready", 32'(o_ready), 32'd1);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rmul ready_post", 32'(o_ready), 32'd1);
        vcount = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge i_clk);
            if (o_valid) vcount++;
        end
        check("rmul no_valid", 32'(vcount), 32'd0);

        // Unit still works after the aborted multiply.
        do_op("post_rst_mul", 3'd4, 8'h64, 8'h02, 9, 8'hC8, 4'b0011);
        check("exp_q empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
